// File: rtl/life_pkg.sv
// life_pkg
// Shared definitions for the life generation step controller:
//   state_t     - step-controller FSM state encoding
//   tick_period - clk cycles per generation tick for a given speed setting
package life_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,  // idle, waiting for run or a single-step request
    ST_RUN   = 2'd1,  // free-running, waiting for the next tick
    ST_ARMED = 2'd2   // one step pending, waiting for a frame
  } state_t;

  // Each speed increment halves the tick period.
  function automatic logic [31:0] tick_period(input logic [31:0] clk_hz,
                                              input logic [31:0] speed);
    return clk_hz >> speed;
  endfunction

endpackage

// File: rtl/life_tick_div.sv
// life_tick_div
// Generation tick divider. Counts 0..(CLK_HZ>>speed)-1 while enabled and
// flags the terminal count as a tick, wrapping back to 0.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset
//   clear  - synchronous counter clear (wins over enable)
//   enable - count enable
//   speed  - speed select, period = CLK_HZ >> speed
//   tick   - high during the cycle the counter sits at its terminal count
module life_tick_div
  import life_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int          SPEED_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_period;
  logic [CNT_W-1:0] w_term;

  always_comb begin
    w_period = tick_period(32'(CLK_HZ), 32'(speed));
    // A speed larger than log2(CLK_HZ) would give a zero period; tick every cycle instead.
    if (w_period == 32'd0) begin
      w_period = 32'd1;
    end
    w_term = CNT_W'(w_period - 32'd1);
  end

  assign tick = enable && !clear && (r_cnt == w_term);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == w_term) ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/life_step_ctrl.sv
// life_step_ctrl
// Decides when the life arrays advance one generation. Steps come either from
// a free-running tick (run=1) or a single-step request (paused), and are
// always released on a video frame boundary while no cell edit is active.
// Ports:
//   clk       - system clock (rising edge)
//   reset     - asynchronous active-high reset
//   run       - level, free-running mode
//   single    - single-step request, rising-edge detected, honoured when paused
//   speed     - tick period = CLK_HZ >> speed
//   frame     - one-cycle frame start pulse
//   write_enb - cell edit in progress, holds off the step
//   step      - one-cycle generation advance pulse
//   armed     - a step is pending a frame
//   gen_count - generations issued (wrapping)
//   overrun   - sticky, a tick arrived while a step was already pending
module life_step_ctrl
  import life_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int          GEN_W   = 16,
  parameter int          SPEED_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               single,
  input  logic [SPEED_W-1:0] speed,
  input  logic               frame,
  input  logic               write_enb,
  output logic               step,
  output logic               armed,
  output logic [GEN_W-1:0]   gen_count,
  output logic               overrun
);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_step_next;
  logic               r_single_prev;
  logic [SPEED_W-1:0] r_speed_prev;
  logic               w_single_rise;
  logic               w_tick;
  logic               w_tick_clear;
  logic               w_tick_en;
  logic               r_step;
  logic               r_armed;
  logic [GEN_W-1:0]   r_gen;
  logic               r_overrun;

  assign w_single_rise = single && !r_single_prev;

  // Restart the period whenever free-running stops or the speed changes, so a
  // new speed always yields a full new period before its first tick.
  assign w_tick_clear = !run || (speed != r_speed_prev);
  // The divider keeps counting while a step is pending so that a too-slow
  // frame/edit release shows up as an overrun.
  assign w_tick_en    = (r_state != ST_PAUSE);

  life_tick_div #(
    .CLK_HZ  (CLK_HZ),
    .SPEED_W (SPEED_W)
  ) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_tick_clear),
    .enable (w_tick_en),
    .speed  (speed),
    .tick   (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_step_next  = 1'b0;
    case (r_state)
      ST_PAUSE: begin
        if (w_single_rise) begin
          w_state_next = ST_ARMED;
        end else if (run) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!run) begin
          w_state_next = ST_PAUSE;
        end else if (w_tick) begin
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // run is only consulted on release: dropping it never cancels a pending step.
        if (frame && !write_enb) begin
          w_step_next  = 1'b1;
          w_state_next = run ? ST_RUN : ST_PAUSE;
        end
      end
      default: begin
        w_state_next = ST_PAUSE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_PAUSE;
      r_single_prev <= 1'b0;
      r_speed_prev  <= '0;
      r_step        <= 1'b0;
      r_armed       <= 1'b0;
      r_gen         <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_single_prev <= single;
      r_speed_prev  <= speed;
      r_step        <= w_step_next;
      r_armed       <= (w_state_next == ST_ARMED);
      if (w_step_next) begin
        r_gen <= r_gen + GEN_W'(1);
      end
      if ((r_state == ST_ARMED) && w_tick) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign step      = r_step;
  assign armed     = r_armed;
  assign gen_count = r_gen;
  assign overrun   = r_overrun;

endmodule
